// File: rtl/memaccess.sv
// -----------------------------------------------------------------------------
// memaccess -- memory-access (M) stage of the 5-stage MIPS pipeline.
//
// Sits between the execute->memory and memory->writeback pipeline registers.
// Performs byte / halfword / word loads and stores over a data-memory bus that
// may insert wait states, stalls the upstream pipeline while the bus is busy,
// aborts an access that waits too long, and registers the results into the
// M/W pipeline register.
//
// Ports
//   i_clk, i_nrst            clock (rising edge), asynchronous active-low reset
//   i_data_pc4               PC+4 of the instruction in M
//   i_data_alures            ALU result / effective address
//   i_data_rt                store data (already forwarded)
//   i_addr_regdst            destination register
//   i_con_Mmemread/_Mmemwrite load / store request (both set = store)
//   i_con_Msize              00 byte, 01 half, 1x word
//   i_con_Msigned            sign-extend byte/half loads
//   i_con_W*                 writeback controls carried into M/W
//   o_dmem_*                 data-memory bus request side
//   i_dmem_ack/_rdata        data-memory bus response side
//   o_con_stall              freeze PC, F/D and D/E/M registers
//   o_data_FMalures          M-stage forwarding value (= i_data_alures)
//   o_data_FWmemout          W-stage forwarding value (= o_data_memout)
//   o_data_*/o_addr_regdst/o_con_W*  M/W pipeline register
//   o_con_misalign/_buserr   one-cycle exception pulses
// -----------------------------------------------------------------------------
module memaccess #(
    parameter int P_TIMEOUT = 255   // max wait cycles for ack (1..1023)
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_data_pc4,
    input  logic [31:0] i_data_alures,
    input  logic [31:0] i_data_rt,
    input  logic [4:0]  i_addr_regdst,
    input  logic        i_con_Mmemread,
    input  logic        i_con_Mmemwrite,
    input  logic [1:0]  i_con_Msize,
    input  logic        i_con_Msigned,
    input  logic        i_con_Walupc8,
    input  logic        i_con_Wmemtoreg,
    input  logic        i_con_Wregwrite,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_con_stall,
    output logic [31:0] o_data_FMalures,
    output logic [31:0] o_data_FWmemout,
    output logic [31:0] o_data_pc4,
    output logic [31:0] o_data_alures,
    output logic [31:0] o_data_memout,
    output logic [4:0]  o_addr_regdst,
    output logic        o_con_Walupc8,
    output logic        o_con_Wmemtoreg,
    output logic        o_con_Wregwrite,
    output logic        o_con_misalign,
    output logic        o_con_buserr
);

    localparam logic [9:0] LP_TIMEOUT = 10'(P_TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;

    logic [31:0] pc4_q, pc4_d;
    logic [31:0] alures_q, alures_d;
    logic [31:0] memout_q, memout_d;
    logic [4:0]  regdst_q, regdst_d;
    logic        walupc8_q, walupc8_d;
    logic        wmemtoreg_q, wmemtoreg_d;
    logic        wregwrite_q, wregwrite_d;
    logic        misalign_q, misalign_d;
    logic        buserr_q, buserr_d;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    logic access;
    logic is_byte;
    logic is_half;
    logic aligned;
    logic misalign;
    logic req;
    logic abort;
    logic complete;
    logic is_load;

    assign access  = i_con_Mmemread | i_con_Mmemwrite;
    assign is_byte = (i_con_Msize == 2'b00);
    assign is_half = (i_con_Msize == 2'b01);
    assign aligned = is_byte
                   | (is_half & ~i_data_alures[0])
                   | (i_con_Msize[1] & (i_data_alures[1:0] == 2'b00));
    // A store wins when both read and write are set.
    assign is_load = i_con_Mmemread & ~i_con_Mmemwrite;

    // Request and the exception decode are gated by reset so that the bus and
    // the stall line go quiet the moment reset is asserted, even mid-access.
    assign misalign = i_nrst & (state_q == ST_IDLE) & access & ~aligned;
    assign req      = i_nrst & (((state_q == ST_IDLE) & access & aligned)
                              | (state_q == ST_WAIT));
    assign abort    = (state_q == ST_WAIT) & ~i_dmem_ack & (cnt_q == LP_TIMEOUT);
    assign complete = req & i_dmem_ack;

    // The stall is released in the abort cycle so the pipeline moves on.
    assign o_con_stall = req & ~i_dmem_ack & ~abort;

    // -------------------------------------------------------------------------
    // Store lane steering and byte enables
    // -------------------------------------------------------------------------
    logic [31:0] wdata;
    logic [3:0]  be_raw;

    // NOTE: every signal written in an always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        wdata  = i_data_rt;
        be_raw = 4'b1111;
        case (i_con_Msize)
            2'b00: begin
                wdata  = {4{i_data_rt[7:0]}};
                be_raw = 4'b0001 << i_data_alures[1:0];
            end
            2'b01: begin
                wdata  = {2{i_data_rt[15:0]}};
                be_raw = i_data_alures[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata  = i_data_rt;
                be_raw = 4'b1111;
            end
        endcase
    end

    assign o_dmem_req   = req;
    assign o_dmem_we    = req & i_con_Mmemwrite;
    assign o_dmem_addr  = {i_data_alures[31:2], 2'b00};
    assign o_dmem_be    = req ? be_raw : 4'b0000;
    assign o_dmem_wdata = wdata;

    // -------------------------------------------------------------------------
    // Load lane extraction
    // -------------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = i_dmem_rdata[{i_data_alures[1:0], 3'b000} +: 8];
        ld_half = i_data_alures[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        ld_data = i_dmem_rdata;
        case (i_con_Msize)
            2'b00: ld_data = i_con_Msigned ? {{24{ld_byte[7]}}, ld_byte}
                                           : {24'h000000, ld_byte};
            2'b01: ld_data = i_con_Msigned ? {{16{ld_half[15]}}, ld_half}
                                           : {16'h0000, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus FSM: next state and wait counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !i_dmem_ack) begin
                    state_d = ST_WAIT;
                    cnt_d   = 10'd1;
                end
            end
            ST_WAIT: begin
                if (i_dmem_ack || abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 10'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // M/W pipeline register next value
    // -------------------------------------------------------------------------
    always_comb begin
        pc4_d       = pc4_q;
        alures_d    = alures_q;
        memout_d    = memout_q;
        regdst_d    = regdst_q;
        walupc8_d   = 1'b0;
        wmemtoreg_d = 1'b0;
        wregwrite_d = 1'b0;
        misalign_d  = 1'b0;
        buserr_d    = 1'b0;

        if (o_con_stall || misalign || abort) begin
            // Bubble: writeback controls cleared, data fields hold.
            misalign_d = misalign;
            buserr_d   = abort;
        end else begin
            pc4_d       = i_data_pc4;
            alures_d    = i_data_alures;
            memout_d    = (complete && is_load) ? ld_data : 32'h0000_0000;
            regdst_d    = i_addr_regdst;
            walupc8_d   = i_con_Walupc8;
            wmemtoreg_d = i_con_Wmemtoreg;
            wregwrite_d = i_con_Wregwrite;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its _d value from before the edge, independent of order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 10'd0;
            pc4_q       <= 32'h0000_0000;
            alures_q    <= 32'h0000_0000;
            memout_q    <= 32'h0000_0000;
            regdst_q    <= 5'd0;
            walupc8_q   <= 1'b0;
            wmemtoreg_q <= 1'b0;
            wregwrite_q <= 1'b0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc4_q       <= pc4_d;
            alures_q    <= alures_d;
            memout_q    <= memout_d;
            regdst_q    <= regdst_d;
            walupc8_q   <= walupc8_d;
            wmemtoreg_q <= wmemtoreg_d;
            wregwrite_q <= wregwrite_d;
            misalign_q  <= misalign_d;
            buserr_q    <= buserr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_data_FMalures = i_data_alures;
    assign o_data_FWmemout = memout_q;
    assign o_data_pc4      = pc4_q;
    assign o_data_alures   = alures_q;
    assign o_data_memout   = memout_q;
    assign o_addr_regdst   = regdst_q;
    assign o_con_Walupc8   = walupc8_q;
    assign o_con_Wmemtoreg = wmemtoreg_q;
    assign o_con_Wregwrite = wregwrite_q;
    assign o_con_misalign  = misalign_q;
    assign o_con_buserr    = buserr_q;

endmodule

// File: tb/tb_memaccess.sv
// -----------------------------------------------------------------------------
// tb_memaccess -- self-checking bench for memaccess (P_TIMEOUT = 4).
// Bus-side outputs are checked inline by each test task just before the rising
// edge; the expected M/W register contents are pushed to a scoreboard queue
// when a cycle is driven and compared by a monitor 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_memaccess;

    logic        i_clk;
    logic        i_nrst;
    logic [31:0] i_data_pc4;
    logic [31:0] i_data_alures;
    logic [31:0] i_data_rt;
    logic [4:0]  i_addr_regdst;
    logic        i_con_Mmemread;
    logic        i_con_Mmemwrite;
    logic [1:0]  i_con_Msize;
    logic        i_con_Msigned;
    logic        i_con_Walupc8;
    logic        i_con_Wmemtoreg;
    logic        i_con_Wregwrite;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_con_stall;
    logic [31:0] o_data_FMalures;
    logic [31:0] o_data_FWmemout;
    logic [31:0] o_data_pc4;
    logic [31:0] o_data_alures;
    logic [31:0] o_data_memout;
    logic [4:0]  o_addr_regdst;
    logic        o_con_Walupc8;
    logic        o_con_Wmemtoreg;
    logic        o_con_Wregwrite;
    logic        o_con_misalign;
    logic        o_con_buserr;

    memaccess #(.P_TIMEOUT(4)) dut (
        .i_clk           (i_clk),
        .i_nrst          (i_nrst),
        .i_data_pc4      (i_data_pc4),
        .i_data_alures   (i_data_alures),
        .i_data_rt       (i_data_rt),
        .i_addr_regdst   (i_addr_regdst),
        .i_con_Mmemread  (i_con_Mmemread),
        .i_con_Mmemwrite (i_con_Mmemwrite),
        .i_con_Msize     (i_con_Msize),
        .i_con_Msigned   (i_con_Msigned),
        .i_con_Walupc8   (i_con_Walupc8),
        .i_con_Wmemtoreg (i_con_Wmemtoreg),
        .i_con_Wregwrite (i_con_Wregwrite),
        .o_dmem_req      (o_dmem_req),
        .o_dmem_we       (o_dmem_we),
        .o_dmem_addr     (o_dmem_addr),
        .o_dmem_be       (o_dmem_be),
        .o_dmem_wdata    (o_dmem_wdata),
        .i_dmem_ack      (i_dmem_ack),
        .i_dmem_rdata    (i_dmem_rdata),
        .o_con_stall     (o_con_stall),
        .o_data_FMalures (o_data_FMalures),
        .o_data_FWmemout (o_data_FWmemout),
        .o_data_pc4      (o_data_pc4),
        .o_data_alures   (o_data_alures),
        .o_data_memout   (o_data_memout),
        .o_addr_regdst   (o_addr_regdst),
        .o_con_Walupc8   (o_con_Walupc8),
        .o_con_Wmemtoreg (o_con_Wmemtoreg),
        .o_con_Wregwrite (o_con_Wregwrite),
        .o_con_misalign  (o_con_misalign),
        .o_con_buserr    (o_con_buserr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef enum int {K_NORMAL, K_BUBBLE, K_MIS, K_ABORT} kind_e;

    typedef struct {
        int          id;
        logic [31:0] pc4;
        logic [31:0] alures;
        logic [31:0] memout;
        logic [4:0]  regdst;
        logic [2:0]  wctl;      // {alupc8, memtoreg, regwrite}
        logic        misalign;
        logic        buserr;
    } mw_t;

    mw_t         sb_q[$];
    mw_t         mon_e;
    int          checks;
    int          errors;
    int          cyc_id;
    logic [31:0] hold_pc4;
    logic [31:0] hold_alures;
    logic [31:0] hold_memout;
    logic [4:0]  hold_regdst;

    task automatic clear_hold();
        hold_pc4    = 32'h0;
        hold_alures = 32'h0;
        hold_memout = 32'h0;
        hold_regdst = 5'd0;
    endtask

    // Expected M/W content after the coming edge, from the inputs now driven.
    task automatic push_expected(input kind_e k, input logic [31:0] mem);
        mw_t e;
        cyc_id++;
        e.id = cyc_id;
        e.wctl = 3'b000;
        if (k == K_NORMAL) begin
            hold_pc4    = i_data_pc4;
            hold_alures = i_data_alures;
            hold_memout = mem;
            hold_regdst = i_addr_regdst;
            e.wctl      = {i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite};
        end
        e.pc4      = hold_pc4;
        e.alures   = hold_alures;
        e.memout   = hold_memout;
        e.regdst   = hold_regdst;
        e.misalign = (k == K_MIS);
        e.buserr   = (k == K_ABORT);
        sb_q.push_back(e);
    endtask

    always @(posedge i_clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({o_data_pc4, o_data_alures, o_data_memout, o_data_FWmemout, o_addr_regdst,
                 o_con_Walupc8, o_con_Wmemtoreg, o_con_Wregwrite, o_con_misalign, o_con_buserr}
                !== {mon_e.pc4, mon_e.alures, mon_e.memout, mon_e.memout, mon_e.regdst,
                     mon_e.wctl, mon_e.misalign, mon_e.buserr}) begin
                errors++;
                $display("FAIL mw_reg#%0d got pc4=%h alu=%h mem=%h fw=%h rd=%0d wctl=%b mis=%b berr=%b exp pc4=%h alu=%h mem=%h rd=%0d wctl=%b mis=%b berr=%b",
                         mon_e.id, o_data_pc4, o_data_alures, o_data_memout, o_data_FWmemout,
                         o_addr_regdst, {o_con_Walupc8, o_con_Wmemtoreg, o_con_Wregwrite},
                         o_con_misalign, o_con_buserr, mon_e.pc4, mon_e.alures, mon_e.memout,
                         mon_e.regdst, mon_e.wctl, mon_e.misalign, mon_e.buserr);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic set_mem(input logic [31:0] pc4, input logic [31:0] alures,
                           input logic [31:0] rt, input logic [4:0] rd,
                           input logic mr, input logic mw, input logic [1:0] sz,
                           input logic sg, input logic [2:0] wctl);
        i_data_pc4      = pc4;
        i_data_alures   = alures;
        i_data_rt       = rt;
        i_addr_regdst   = rd;
        i_con_Mmemread  = mr;
        i_con_Mmemwrite = mw;
        i_con_Msize     = sz;
        i_con_Msigned   = sg;
        {i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite} = wctl;
    endtask

    // ALU-type instruction, no memory access.
    task automatic idle_inputs();
        set_mem(32'h0000_0008, 32'h0000_0055, 32'h0, 5'd3, 1'b0, 1'b0, 2'b10, 1'b0, 3'b001);
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h0;
    endtask

    // -------------------------------------------------------------------------
    // Tests (each starts and ends just after a falling edge)
    // -------------------------------------------------------------------------
    task automatic test_reset();
        i_nrst = 1'b0;
        set_mem(32'h0000_0104, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 1'b0, 2'b10, 1'b0, 3'b011);
        i_dmem_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if ({o_dmem_req, o_con_stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_stall got %b exp 00", {o_dmem_req, o_con_stall});
        end
        checks++;
        if ({o_data_pc4, o_data_alures, o_data_memout, o_addr_regdst, o_con_Walupc8,
             o_con_Wmemtoreg, o_con_Wregwrite, o_con_misalign, o_con_buserr} !== '0) begin
            errors++;
            $display("FAIL reset_regs got pc4=%h alu=%h mem=%h rd=%0d exp all zero",
                     o_data_pc4, o_data_alures, o_data_memout, o_addr_regdst);
        end
        @(negedge i_clk);
        idle_inputs();
        i_nrst = 1'b1;
        clear_hold();
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_req, o_con_stall} !== 2'b00) begin
            errors++;
            $display("FAIL idle_req_stall got %b exp 00", {o_dmem_req, o_con_stall});
        end
        @(negedge i_clk);
    endtask

    task automatic test_word_store();
        set_mem(32'h0000_0404, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h0;
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_req, o_dmem_we, o_dmem_be, o_con_stall} !== {1'b1, 1'b1, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL sw_ctrl got req/we/be/stall=%b exp 1111110",
                     {o_dmem_req, o_dmem_we, o_dmem_be, o_con_stall});
        end
        checks++;
        if ({o_dmem_wdata, o_dmem_addr} !== {32'hDEAD_BEEF, 32'h0000_0100}) begin
            errors++;
            $display("FAIL sw_data got wdata=%h addr=%h exp deadbeef 00000100",
                     o_dmem_wdata, o_dmem_addr);
        end
        checks++;
        if (o_data_FMalures !== 32'h0000_0100) begin
            errors++;
            $display("FAIL fwd_alures got %h exp 00000100", o_data_FMalures);
        end
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
    endtask

    task automatic test_loads();
        logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h101, 32'h102, 32'h100, 32'h104};
        logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        sgns  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0]  bes   [6] = '{4'b1000, 4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
        logic [31:0] mems  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0012,
                                   32'hFFFF_80FF, 32'h0000_1234, 32'h80FF_1234};
        for (int i = 0; i < 6; i++) begin
            set_mem(32'h0000_0500 + 32'(4 * i), addrs[i], 32'h0, 5'(i + 1),
                    1'b1, 1'b0, sizes[i], sgns[i], 3'b011);
            i_dmem_ack   = 1'b1;
            i_dmem_rdata = 32'h80FF_1234;
            push_expected(K_NORMAL, mems[i]);
            #4;
            checks++;
            if ({o_dmem_req, o_dmem_we, o_dmem_be, o_con_stall, o_dmem_addr}
                !== {1'b1, 1'b0, bes[i], 1'b0, addrs[i] & 32'hFFFF_FFFC}) begin
                errors++;
                $display("FAIL load%0d_bus got req/we/be/stall=%b addr=%h exp %b addr=%h",
                         i, {o_dmem_req, o_dmem_we, o_dmem_be, o_con_stall}, o_dmem_addr,
                         {1'b1, 1'b0, bes[i], 1'b0}, addrs[i] & 32'hFFFF_FFFC);
            end
            @(negedge i_clk);
        end
        i_dmem_ack = 1'b0;
    endtask

    task automatic test_half_misalign();
        set_mem(32'h0000_0600, 32'h0000_0022, 32'h0000_ABCD, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 3'b000);
        i_dmem_ack = 1'b1;
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_we, o_dmem_be, o_dmem_wdata} !== {1'b1, 4'b1100, 32'hABCD_ABCD}) begin
            errors++;
            $display("FAIL sh_lane got we=%b be=%b wdata=%h exp 1 1100 abcdabcd",
                     o_dmem_we, o_dmem_be, o_dmem_wdata);
        end
        @(negedge i_clk);
        // Half load at odd address, then word load at a half-aligned address.
        i_dmem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_mem(32'h0000_0604 + 32'(4 * i), (i == 0) ? 32'h0000_0021 : 32'h0000_0102,
                    32'h0, 5'd6, 1'b1, 1'b0, (i == 0) ? 2'b01 : 2'b10, 1'b1, 3'b011);
            push_expected(K_MIS, 32'h0);
            #4;
            checks++;
            if ({o_dmem_req, o_con_stall} !== 2'b00) begin
                errors++;
                $display("FAIL misalign%0d_req got req/stall=%b exp 00", i,
                         {o_dmem_req, o_con_stall});
            end
            @(negedge i_clk);
        end
        idle_inputs();
        push_expected(K_NORMAL, 32'h0);
        @(negedge i_clk);
    endtask

    task automatic test_wait_load();
        int stall_cnt = 0;
        set_mem(32'h0000_0700, 32'h0000_0200, 32'h0, 5'd9, 1'b1, 1'b0, 2'b10, 1'b0, 3'b011);
        for (int c = 0; c < 4; c++) begin
            i_dmem_ack   = (c == 3);
            i_dmem_rdata = (c == 3) ? 32'h1234_5678 : 32'hBAD0_BAD0;
            if (c == 3) push_expected(K_NORMAL, 32'h1234_5678);
            else        push_expected(K_BUBBLE, 32'h0);
            #4;
            if (o_con_stall === 1'b1) stall_cnt++;
            checks++;
            if ({o_dmem_req, o_con_stall} !== {1'b1, (c != 3)}) begin
                errors++;
                $display("FAIL wait_c%0d got req/stall=%b exp %b", c,
                         {o_dmem_req, o_con_stall}, {1'b1, (c != 3)});
            end
            @(negedge i_clk);
        end
        checks++;
        if (stall_cnt != 3) begin
            errors++;
            $display("FAIL wait_stall_cycles got %0d exp 3", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        // Issued the cycle right after the wait-state completion above.
        set_mem(32'h0000_0704, 32'h0000_0204, 32'h1122_3344, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000);
        i_dmem_ack = 1'b1;
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_req, o_con_stall, o_dmem_wdata} !== {2'b10, 32'h1122_3344}) begin
            errors++;
            $display("FAIL b2b_sw got req/stall=%b wdata=%h exp 10 11223344",
                     {o_dmem_req, o_con_stall}, o_dmem_wdata);
        end
        @(negedge i_clk);
        set_mem(32'h0000_0708, 32'h0000_0207, 32'h0000_00AA, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000);
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_we, o_dmem_be, o_dmem_wdata} !== {1'b1, 4'b1000, 32'hAAAA_AAAA}) begin
            errors++;
            $display("FAIL b2b_sb got we=%b be=%b wdata=%h exp 1 1000 aaaaaaaa",
                     o_dmem_we, o_dmem_be, o_dmem_wdata);
        end
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        set_mem(32'h0000_0800, 32'h0000_0300, 32'h0, 5'd7, 1'b1, 1'b0, 2'b10, 1'b0, 3'b011);
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'hBAD0_BAD0;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) push_expected(K_BUBBLE, 32'h0);
            else       push_expected(K_ABORT, 32'h0);
            #4;
            checks++;
            if ({o_dmem_req, o_con_stall} !== {1'b1, (c < 4)}) begin
                errors++;
                $display("FAIL timeout_c%0d got req/stall=%b exp %b", c,
                         {o_dmem_req, o_con_stall}, {1'b1, (c < 4)});
            end
            @(negedge i_clk);
        end
        // Late ack with nothing in flight must be ignored.
        idle_inputs();
        i_dmem_ack = 1'b1;
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_req, o_con_stall} !== 2'b00) begin
            errors++;
            $display("FAIL late_ack got req/stall=%b exp 00", {o_dmem_req, o_con_stall});
        end
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_mem(32'h0000_0900, 32'h0000_0400, 32'h0000_5555, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000);
        i_dmem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            push_expected(K_BUBBLE, 32'h0);
            @(negedge i_clk);
        end
        #2;
        i_nrst = 1'b0;
        #1;
        checks++;
        if ({o_dmem_req, o_con_stall} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_req got req/stall=%b exp 00", {o_dmem_req, o_con_stall});
        end
        checks++;
        if ({o_data_pc4, o_data_alures, o_data_memout, o_addr_regdst, o_con_Walupc8,
             o_con_Wmemtoreg, o_con_Wregwrite, o_con_misalign, o_con_buserr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_regs got pc4=%h alu=%h mem=%h rd=%0d exp all zero",
                     o_data_pc4, o_data_alures, o_data_memout, o_addr_regdst);
        end
        @(negedge i_clk);
        idle_inputs();
        i_nrst = 1'b1;
        clear_hold();
        push_expected(K_NORMAL, 32'h0);
        #4;
        checks++;
        if ({o_dmem_req, o_con_stall} !== 2'b00) begin
            errors++;
            $display("FAIL post_rst_idle got req/stall=%b exp 00", {o_dmem_req, o_con_stall});
        end
        @(negedge i_clk);
        set_mem(32'h0000_0A00, 32'h0000_0500, 32'h0, 5'd12, 1'b1, 1'b0, 2'b10, 1'b0, 3'b111);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hCAFE_F00D;
        push_expected(K_NORMAL, 32'hCAFE_F00D);
        #4;
        checks++;
        if ({o_dmem_req, o_con_stall} !== 2'b10) begin
            errors++;
            $display("FAIL post_rst_load got req/stall=%b exp 10", {o_dmem_req, o_con_stall});
        end
        @(negedge i_clk);
        idle_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        cyc_id = 0;
        clear_hold();
        idle_inputs();
        i_nrst = 1'b0;
        test_reset();
        test_word_store();
        test_loads();
        test_half_misalign();
        test_wait_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        @(posedge i_clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
